// File: rtl/seq_alu_if.sv
// Handshake and datapath bundle between the control unit (master) and seq_alu (slave).
interface seq_alu_if #(
   parameter int WIDTH = 18
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] y;
   logic             z;
   logic             n;
   logic             co;
   logic             v;

   modport master (output start, op, a, b, input ready, done, y, z, n, co, v);
   modport slave  (input start, op, a, b, output ready, done, y, z, n, co, v);
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/ready/done handshake, iterative shifts and optional
// shift-add multiplier (built only when SEQ_ALU_MUL_EN is defined).
module seq_alu #(
   parameter int WIDTH = 18,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic     C,
   input logic     R,
   seq_alu_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [SHW:0] W_CNT   = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

   function automatic logic is_zero(input logic [WIDTH-1:0] val);
      return (val == {WIDTH{1'b0}});
   endfunction

   logic [1:0]       state_r;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [SHW:0]     cnt_r;
   logic             ready_r, done_r;
   logic [WIDTH-1:0] y_r;
   logic             z_r, n_r, co_r, v_r;

   logic [WIDTH-1:0] bb_s;
   logic [WIDTH:0]   sum_s;
   logic [SHW:0]     kx_s, kc_s;
   logic [WIDTH-1:0] quick_y_s;
   logic             quick_co_s, quick_v_s, multi_s;
   logic [WIDTH-1:0] sh_nxt_s;
   logic             sh_out_s;
   logic [WIDTH-1:0] fin_y_s;
   logic             fin_co_s, fin_v_s;

`ifdef SEQ_ALU_MUL_EN
   logic [2*WIDTH-1:0] p_r;
   logic [WIDTH:0]     psum_s;
   logic [2*WIDTH-1:0] p_nxt_s;
`endif

   // Results of single-cycle ops and EXEC entry decision, from the live request
   always_comb begin
      bb_s       = (bus.op == OP_SUB) ? ~bus.b : bus.b;
      sum_s      = {1'b0, bus.a} + {1'b0, bb_s} + {{WIDTH{1'b0}}, (bus.op == OP_SUB)};
      kx_s       = {1'b0, bus.b[SHW-1:0]};
      // amounts past WIDTH only shift zeros in, so stop after WIDTH steps
      kc_s       = (kx_s > W_CNT) ? W_CNT : kx_s;
      quick_y_s  = {WIDTH{1'b0}};
      quick_co_s = 1'b0;
      quick_v_s  = 1'b0;
      multi_s    = 1'b0;
      case (bus.op)
         OP_ADD, OP_SUB: begin
            quick_y_s  = sum_s[WIDTH-1:0];
            quick_co_s = sum_s[WIDTH];
            quick_v_s  = (bus.a[WIDTH-1] == bb_s[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND: quick_y_s = bus.a & bus.b;
         OP_OR:  quick_y_s = bus.a | bus.b;
         OP_XOR: quick_y_s = bus.a ^ bus.b;
         OP_SHL, OP_SHR: begin
            quick_y_s = bus.a;
            multi_s   = (kx_s != {(SHW+1){1'b0}});
         end
`ifdef SEQ_ALU_MUL_EN
         OP_MUL: multi_s = 1'b1;
`else
         OP_MUL: quick_v_s = 1'b1;
`endif
         default: quick_y_s = {WIDTH{1'b0}};
      endcase
   end

   // One-bit logical shift step of the working register
   always_comb begin
      if (op_r == OP_SHL) begin
         sh_nxt_s = {a_r[WIDTH-2:0], 1'b0};
         sh_out_s = a_r[WIDTH-1];
      end else begin
         sh_nxt_s = {1'b0, a_r[WIDTH-1:1]};
         sh_out_s = a_r[0];
      end
   end

`ifdef SEQ_ALU_MUL_EN
   // Shift-add step: p holds {partial product, remaining multiplier bits}
   always_comb begin
      psum_s  = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
      p_nxt_s = {psum_s, p_r[WIDTH-1:1]};
   end
`endif

   // Result and flags produced by the last EXEC iteration
   always_comb begin
      fin_y_s  = sh_nxt_s;
      fin_co_s = sh_out_s;
      fin_v_s  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
      if (op_r == OP_MUL) begin
         fin_y_s  = p_nxt_s[WIDTH-1:0];
         fin_co_s = 1'b0;
         fin_v_s  = |p_nxt_s[2*WIDTH-1:WIDTH];
      end else begin
         fin_y_s  = sh_nxt_s;
         fin_co_s = sh_out_s;
         fin_v_s  = 1'b0;
      end
`endif
   end

   // Control FSM, working registers and registered result/flags
   always_ff @(posedge C) begin
      if (R) begin
         state_r <= S_IDLE;
         op_r    <= OP_ADD;
         a_r     <= {WIDTH{1'b0}};
         cnt_r   <= {(SHW+1){1'b0}};
         ready_r <= 1'b1;
         done_r  <= 1'b0;
         y_r     <= {WIDTH{1'b0}};
         z_r     <= 1'b0;
         n_r     <= 1'b0;
         co_r    <= 1'b0;
         v_r     <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         p_r     <= {(2*WIDTH){1'b0}};
`endif
      end else begin
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  op_r    <= bus.op;
                  a_r     <= bus.a;
                  ready_r <= 1'b0;
                  if (multi_s) begin
                     state_r <= S_EXEC;
`ifdef SEQ_ALU_MUL_EN
                     cnt_r   <= (bus.op == OP_MUL) ? W_CNT : kc_s;
                     p_r     <= {{WIDTH{1'b0}}, bus.b};
`else
                     cnt_r   <= kc_s;
`endif
                  end else begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                     y_r     <= quick_y_s;
                     z_r     <= is_zero(quick_y_s);
                     n_r     <= quick_y_s[WIDTH-1];
                     co_r    <= quick_co_s;
                     v_r     <= quick_v_s;
                  end
               end
            end
            S_EXEC: begin
               cnt_r <= cnt_r - CNT_ONE;
`ifdef SEQ_ALU_MUL_EN
               if (op_r == OP_MUL) begin
                  p_r <= p_nxt_s;
               end else begin
                  a_r <= sh_nxt_s;
               end
`else
               a_r <= sh_nxt_s;
`endif
               if (cnt_r == CNT_ONE) begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
                  y_r     <= fin_y_s;
                  z_r     <= is_zero(fin_y_s);
                  n_r     <= fin_y_s[WIDTH-1];
                  co_r    <= fin_co_s;
                  v_r     <= fin_v_s;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
               done_r  <= 1'b0;
               ready_r <= 1'b1;
            end
            default: begin
               state_r <= S_IDLE;
               done_r  <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready = ready_r;
   assign bus.done  = done_r;
   assign bus.y     = y_r;
   assign bus.z     = z_r;
   assign bus.n     = n_r;
   assign bus.co    = co_r;
   assign bus.v     = v_r;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver queues hand-computed results, a
// negedge monitor pops and compares them whenever DONE is seen.
module tb_seq_alu;
   localparam int W = 18;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(W)) bus();

   seq_alu #(.WIDTH(W)) dut (
      .C   (clk),
      .R   (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [W-1:0] y;
      logic         z, n, co, v;
      int           lat;
      int           acc;
   } exp_t;

   exp_t  exp_q[$];
   int    cyc = 0;
   int    n_tests = 0;
   int    n_fail = 0;
   string cur_name = "reset";

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_name, nm, act, expv);
      end
   endtask

   // Monitor: compare on DONE, otherwise READY must stay low while work is pending
   always @(negedge clk) begin
      exp_t e;
      if (bus.done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", {31'd0, bus.done}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("y",        {14'd0, bus.y},  {14'd0, e.y});
            chk("z",        {31'd0, bus.z},  {31'd0, e.z});
            chk("n",        {31'd0, bus.n},  {31'd0, e.n});
            chk("co",       {31'd0, bus.co}, {31'd0, e.co});
            chk("v",        {31'd0, bus.v},  {31'd0, e.v});
            chk("latency",  cyc - e.acc + 1, e.lat);
            chk("ready_in_done", {31'd0, bus.ready}, 32'd0);
         end
      end else if (exp_q.size() != 0) begin
         chk("ready_busy", {31'd0, bus.ready}, 32'd0);
      end
   end

   task automatic push_exp(input logic [W-1:0] ey, input logic ez, en, eco, ev, input int lat);
      exp_t e;
      e.y = ey; e.z = ez; e.n = en; e.co = eco; e.v = ev; e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic wait_ready();
      int t = 0;
      @(negedge clk);
      while (!bus.ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.ready) chk("ready_timeout", {31'd0, bus.ready}, 32'd1);
   endtask

   task automatic issue(input string nm, input logic [2:0] op, input logic [W-1:0] a, b,
                        input logic [W-1:0] ey, input logic ez, en, eco, ev, input int lat);
      wait_ready();
      cur_name  = nm;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      push_exp(ey, ez, en, eco, ev, lat);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      int t;
      int dcyc;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = '0;
      bus.b     = '0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_y",     {14'd0, bus.y}, 32'd0);
      chk("rst_flags", {28'd0, bus.z, bus.n, bus.co, bus.v}, 32'd0);
      chk("rst_ready", {31'd0, bus.ready}, 32'd1);
      chk("rst_done",  {31'd0, bus.done}, 32'd0);

      //     name        op     A          B          Y          Z     N     CO    V     lat
      issue("add_wrap", 3'd0, 18'h3FFFF, 18'h00001, 18'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
      issue("add_ovf",  3'd0, 18'h1FFFF, 18'h00001, 18'h20000, 1'b0, 1'b1, 1'b0, 1'b1, 1);
      issue("sub_neg",  3'd1, 18'h00005, 18'h00007, 18'h3FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      issue("sub_ovf",  3'd1, 18'h1FFFF, 18'h3FFFF, 18'h20000, 1'b0, 1'b1, 1'b0, 1'b1, 1);
      issue("and",      3'd2, 18'h3C3C3, 18'h0FF0F, 18'h0C303, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      issue("or",       3'd3, 18'h20000, 18'h00001, 18'h20001, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      issue("xor_zero", 3'd4, 18'h15555, 18'h15555, 18'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      issue("shl_17",   3'd5, 18'h00001, 18'd17,    18'h20000, 1'b0, 1'b1, 1'b0, 1'b0, 18);
      issue("shr_1",    3'd6, 18'h00003, 18'd1,     18'h00001, 1'b0, 1'b0, 1'b1, 1'b0, 2);
      issue("shl_0",    3'd5, 18'h2A5A5, 18'd0,     18'h2A5A5, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      issue("shl_2",    3'd5, 18'h30000, 18'd2,     18'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 3);
      issue("shr_31",   3'd6, 18'h3FFFF, 18'd31,    18'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 19);
      issue("shl_20",   3'd5, 18'h00001, 18'd20,    18'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 19);
`ifdef SEQ_ALU_MUL_EN
      issue("mul_300",  3'd7, 18'd300,   18'd500,   18'h249F0, 1'b0, 1'b1, 1'b0, 1'b0, 19);
      issue("mul_1000", 3'd7, 18'd1000,  18'd1000,  18'h34240, 1'b0, 1'b1, 1'b0, 1'b1, 19);
      issue("mul_zero", 3'd7, 18'h3FFFF, 18'd0,     18'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 19);
`else
      issue("mul_off",  3'd7, 18'd300,   18'd500,   18'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1);
`endif
      wait_idle();

      // START held high: one accept per operation, next accept right after DONE
      wait_ready();
      cur_name  = "held_start";
      bus.start = 1'b1;
      bus.op    = 3'd7;
      bus.a     = 18'd300;
      bus.b     = 18'd500;
      @(posedge clk);
      #1;
      bus.a = 18'd7;
      bus.b = 18'd9;
`ifdef SEQ_ALU_MUL_EN
      push_exp(18'h249F0, 1'b0, 1'b1, 1'b0, 1'b0, 19);
`else
      push_exp(18'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1);
`endif
      t = 0;
      @(negedge clk);
      while (!bus.done && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("hs_done_seen", {31'd0, bus.done}, 32'd1);
      dcyc = cyc;
      @(posedge clk);
      #1;
      chk("hs_idle_ready", {31'd0, bus.ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("hs_reaccept", {31'd0, bus.ready}, 32'd0);
      chk("hs_accept_cycle", cyc, dcyc + 2);
      bus.start = 1'b0;
`ifdef SEQ_ALU_MUL_EN
      push_exp(18'h0003F, 1'b0, 1'b0, 1'b0, 1'b0, 19);
`else
      push_exp(18'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1);
`endif
      wait_idle();

      // Reset on cycle 5 of a MUL aborts it without a DONE pulse
      wait_ready();
      cur_name  = "reset_midop";
      bus.start = 1'b1;
      bus.op    = 3'd7;
      bus.a     = 18'd1000;
      bus.b     = 18'd1000;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
`ifndef SEQ_ALU_MUL_EN
      push_exp(18'h00000, 1'b1, 1'b0, 1'b0, 1'b1, 1);
`endif
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_y",     {14'd0, bus.y}, 32'd0);
      chk("abort_flags", {28'd0, bus.z, bus.n, bus.co, bus.v}, 32'd0);
      chk("abort_ready", {31'd0, bus.ready}, 32'd1);
      chk("abort_done",  {31'd0, bus.done}, 32'd0);
      repeat (25) @(negedge clk);

      issue("add_after", 3'd0, 18'd2, 18'd3, 18'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      wait_idle();
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
